acc_splitter: RTL and testbench
===============================

ACC_SPLITTER -- requirements
Module: acc_splitter

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 load  input  1  request to start splitting a new total; sampled only in IDLE.
REQ-005 total  input  5  unsigned value (0..31) to split; sampled with load.
REQ-006 max_chunk  input  4  largest chunk allowed per beat (1..15); sampled with load.
REQ-007 ready  input  1  downstream accepts the current chunk this cycle.
REQ-008 out_valid  output  1  chunk/last are valid this cycle.
REQ-009 chunk  output  4  current chunk value.
REQ-010 last  output  1  current chunk is the final one of the split.
REQ-011 remaining  output  5  value still to be emitted, including the current chunk.
REQ-012 busy  output  1  high in EMIT state.
REQ-013 done  output  1  one-cycle pulse in the cycle after the last chunk is accepted.
REQ-014 err  output  1  one-cycle pulse in the cycle after a load with max_chunk==0.

Function
REQ-015 The block SHALL be the inverse of the team's 4-bit-to-5-bit accumulator: the accepted chunks of one split SHALL sum exactly to the loaded total.
REQ-016 FSM states SHALL be IDLE and EMIT only; a beat is accepted when out_valid && ready.
REQ-017 IDLE: out_valid=0, busy=0; on load with max_chunk!=0, latch total into rem_reg and max_chunk into max_reg, go to EMIT next cycle.
REQ-018 IDLE: on load with max_chunk==0, stay in IDLE, pulse err next cycle, leave registers unchanged.
REQ-019 EMIT: out_valid=1, busy=1, chunk=min(rem_reg, max_reg), last=(rem_reg<=max_reg), remaining=rem_reg; all combinational from registers.
REQ-020 EMIT: chunk, last and remaining SHALL hold stable while ready=0.
REQ-021 EMIT accepted beat with last=0: rem_reg <= rem_reg - chunk, stay in EMIT.
REQ-022 EMIT accepted beat with last=1: rem_reg <= 0, go to IDLE, pulse done next cycle.
REQ-023 total==0 SHALL produce exactly one beat: chunk=0, last=1.
REQ-024 Number of beats SHALL equal ceil(total/max_chunk) for total>0; first-beat latency from load is 1 cycle.
REQ-025 load while in EMIT SHALL be ignored (no state, register, or err change).
REQ-026 Subtraction SHALL be 5-bit unsigned and can never underflow, since chunk<=rem_reg.
REQ-027 In IDLE, chunk=0, last=0, remaining=rem_reg.
REQ-028 A new load is accepted in the same cycle done is high, because the block is already in IDLE.

Reset
REQ-029 rst=1 at a clock edge SHALL force IDLE, rem_reg=0, max_reg=0, done=0 and err=0, overriding load and ready.
REQ-030 After reset all outputs SHALL be 0.
REQ-031 Reset mid-split SHALL abandon the split with no done pulse.
REQ-032 The first load is honoured in the first cycle with rst=0.

Verification
REQ-033 total=31, max=15, ready=1 -> chunks 15,15,1 on consecutive cycles; last only on the third; remaining 31,16,1; done 1 cycle later.
REQ-034 total=0, max=7 -> single beat chunk=0 last=1, then done; total=9, max=15 -> single beat chunk=9 last=1.
REQ-035 total=20, max=4, ready toggled 1,0,0,1,... -> five chunks of 4, outputs held during stalls, sum=20, last on fifth accepted beat.
REQ-036 total=10, max=3; during EMIT assert load with total=5 -> ignored; chunks 3,3,3,1 delivered.
REQ-037 load with max_chunk=0 -> err pulses one cycle, busy stays 0, out_valid stays 0.
REQ-038 total=25, max=5; rst after second accepted beat -> next cycle out_valid=0, remaining=0, no done; a fresh load then works normally.

Source files
------------

// File: rtl/acc_splitter.sv
// Splits a 5-bit total into a stream of chunks no larger than max_chunk,
// handshaken with out_valid/ready; the accepted chunks always sum to the total.
module acc_splitter (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [4:0] total,
    input  logic [3:0] max_chunk,
    input  logic       ready,
    output logic       out_valid,
    output logic [3:0] chunk,
    output logic       last,
    output logic [4:0] remaining,
    output logic       busy,
    output logic       done,
    output logic       err
);

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [4:0] rem_q, rem_d;
    logic [3:0] max_q, max_d;
    logic       done_q, done_d;
    logic       err_q, err_d;

    logic       fits;
    logic       accept;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rem_q   <= 5'd0;
            max_q   <= 4'd0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            max_q   <= max_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // The remainder fits in one beat when it does not exceed the per-beat limit.
    assign fits   = (rem_q <= {1'b0, max_q});
    assign accept = (state_q == EMIT) && ready;

    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        max_d     = max_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        chunk     = 4'd0;
        last      = 1'b0;
        remaining = rem_q;

        case (state_q)
            IDLE: begin
                if (load) begin
                    if (max_chunk == 4'd0) begin
                        err_d = 1'b1;
                    end else begin
                        rem_d   = total;
                        max_d   = max_chunk;
                        state_d = EMIT;
                    end
                end
            end
            EMIT: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                chunk     = fits ? rem_q[3:0] : max_q;
                last      = fits;
                // chunk never exceeds rem_q, so this subtraction cannot wrap.
                if (accept) begin
                    if (fits) begin
                        rem_d   = 5'd0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        rem_d = rem_q - {1'b0, chunk};
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign done = done_q;
    assign err  = err_q;

endmodule

// File: tb/tb_acc_splitter.sv
// Directed bench for acc_splitter with hand-computed expected beats.
module tb_acc_splitter;

    logic       clk = 1'b0;
    logic       rst;
    logic       load;
    logic [4:0] total;
    logic [3:0] max_chunk;
    logic       ready;
    logic       out_valid;
    logic [3:0] chunk;
    logic       last;
    logic [4:0] remaining;
    logic       busy;
    logic       done;
    logic       err;

    int n_chk  = 0;
    int n_pass = 0;

    acc_splitter dut (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .total     (total),
        .max_chunk (max_chunk),
        .ready     (ready),
        .out_valid (out_valid),
        .chunk     (chunk),
        .last      (last),
        .remaining (remaining),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input string tag, input int c, input int l, input int r);
        chk({tag, ".valid"}, int'(out_valid), 1);
        chk({tag, ".busy"},  int'(busy), 1);
        chk({tag, ".chunk"}, int'(chunk), c);
        chk({tag, ".last"},  int'(last), l);
        chk({tag, ".rem"},   int'(remaining), r);
    endtask

    task automatic idle(input string tag, input int d, input int e, input int r);
        chk({tag, ".valid"}, int'(out_valid), 0);
        chk({tag, ".busy"},  int'(busy), 0);
        chk({tag, ".chunk"}, int'(chunk), 0);
        chk({tag, ".last"},  int'(last), 0);
        chk({tag, ".rem"},   int'(remaining), r);
        chk({tag, ".done"},  int'(done), d);
        chk({tag, ".err"},   int'(err), e);
    endtask

    initial begin
        int acc;
        int sum;
        int rem_m;

        rst = 1'b1; load = 1'b0; total = '0; max_chunk = '0; ready = 1'b0;
        tick();
        tick();
        idle("reset", 0, 0, 0);

        // 31 split by 15, load on first cycle out of reset
        rst = 1'b0; load = 1'b1; total = 5'd31; max_chunk = 4'd15; ready = 1'b1;
        tick();
        load = 1'b0;
        beat("t31.b1", 15, 0, 31);
        tick();
        beat("t31.b2", 15, 0, 16);
        tick();
        beat("t31.b3", 1, 1, 1);
        tick();
        idle("t31.done", 1, 0, 0);
        tick();
        chk("t31.done_pulse", int'(done), 0);

        // total 0 then back-to-back load during the done cycle
        load = 1'b1; total = 5'd0; max_chunk = 4'd7;
        tick();
        load = 1'b0;
        beat("t0.b1", 0, 1, 0);
        tick();
        idle("t0.done", 1, 0, 0);
        load = 1'b1; total = 5'd9; max_chunk = 4'd15;
        tick();
        load = 1'b0;
        beat("t9.b1", 9, 1, 9);
        tick();
        idle("t9.done", 1, 0, 0);

        // 20 by 4 with stalls: ready pattern 1,0,0,1,0,0,...
        load = 1'b1; total = 5'd20; max_chunk = 4'd4; ready = 1'b0;
        tick();
        load = 1'b0;
        acc = 0; sum = 0; rem_m = 20;
        for (int i = 0; i < 30 && acc < 5; i++) begin
            beat("t20.beat", 4, (acc == 4) ? 1 : 0, rem_m);
            ready = ((i % 3) == 0);
            if (ready) begin
                acc++;
                sum += 4;
                rem_m -= 4;
            end
            tick();
        end
        ready = 1'b1;
        chk("t20.beats", acc, 5);
        chk("t20.sum", sum, 20);
        idle("t20.done", 1, 0, 0);

        // load during EMIT must be ignored
        load = 1'b1; total = 5'd10; max_chunk = 4'd3;
        tick();
        total = 5'd5; max_chunk = 4'd1;
        beat("t10.b1", 3, 0, 10);
        tick();
        beat("t10.b2", 3, 0, 7);
        chk("t10.err", int'(err), 0);
        tick();
        beat("t10.b3", 3, 0, 4);
        load = 1'b0;
        tick();
        beat("t10.b4", 1, 1, 1);
        tick();
        idle("t10.done", 1, 0, 0);

        // max_chunk == 0 raises err and stays idle
        load = 1'b1; total = 5'd7; max_chunk = 4'd0;
        tick();
        load = 1'b0;
        idle("err.pulse", 0, 1, 0);
        tick();
        idle("err.clear", 0, 0, 0);

        // reset mid-split, then a fresh load
        load = 1'b1; total = 5'd25; max_chunk = 4'd5;
        tick();
        load = 1'b0;
        beat("t25.b1", 5, 0, 25);
        tick();
        beat("t25.b2", 5, 0, 20);
        tick();
        beat("t25.b3", 5, 0, 15);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        idle("t25.rst", 0, 0, 0);
        tick();
        idle("t25.nodone", 0, 0, 0);
        load = 1'b1; total = 5'd7; max_chunk = 4'd5;
        tick();
        load = 1'b0;
        beat("t7.b1", 5, 0, 7);
        tick();
        beat("t7.b2", 2, 1, 2);
        tick();
        idle("t7.done", 1, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
